// File: rtl/segway_pkg.sv
// segway_pkg: shared state encoding and default thresholds for the rider/steer-enable logic
package segway_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, STEER} steer_state_t;
  localparam logic [11:0] MIN_RIDER_WT = 12'h200;
  localparam logic [11:0] WT_HYST = 12'h040;
  localparam logic [11:0] BATT_THRES = 12'h800;
  localparam logic [11:0] BATT_HYST = 12'h020;
endpackage

// File: rtl/rider_steer_en_settle_timer.sv
// settle_timer: W-bit saturating up-counter with synchronous clear and count enable
module settle_timer #(
  parameter int W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_full
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : (i_en && !o_full) ? r_cnt + W'(1) : r_cnt;
  assign o_full = &r_cnt;
endmodule

// File: rtl/rider_steer_en.sv
// rider_steer_en: rider-present/balance detector gating the steering path after a settle period
// Optional battery-low lockout of mounting is compiled in with RIDER_BATT_LOW_EN.
module rider_steer_en #(
  parameter logic [11:0] MIN_RIDER_WT = segway_pkg::MIN_RIDER_WT,
  parameter logic [11:0] WT_HYST = segway_pkg::WT_HYST,
  parameter int TMR_W = 26
`ifdef RIDER_BATT_LOW_EN
  , parameter logic [11:0] BATT_THRES = segway_pkg::BATT_THRES,
  parameter logic [11:0] BATT_HYST = segway_pkg::BATT_HYST
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic        en_steer,
  output logic        rider_off,
  output logic        batt_low
);
  import segway_pkg::*;
  localparam logic [12:0] ON_TH = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] GONE_TH = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
  steer_state_t r_state, w_next;
  logic [11:0] r_lft_q, r_rght_q, r_batt_q, w_diff;
  logic [12:0] w_sum;
  logic w_rider_on, w_rider_gone, w_unbal, w_tilt, w_full, w_blk, w_tmr_clr;
  always_ff @(posedge clk)
    if (rst) {r_lft_q, r_rght_q, r_batt_q} <= '0;
    else if (nxt) {r_lft_q, r_rght_q, r_batt_q} <= {lft_ld, rght_ld, batt};
  assign w_sum = {1'b0, r_lft_q} + {1'b0, r_rght_q};
  assign w_diff = (r_lft_q > r_rght_q) ? r_lft_q - r_rght_q : r_rght_q - r_lft_q;
  assign w_rider_on = w_sum >= ON_TH;
  assign w_rider_gone = w_sum < GONE_TH;
  // full-width compares: 4*diff vs sum in 15 bits, 16*diff vs 15*sum in 17 bits
  assign w_unbal = {1'b0, w_diff, 2'b00} > {2'b00, w_sum};
  assign w_tilt = {1'b0, w_diff, 4'b0000} > (({4'b0000, w_sum} << 4) - {4'b0000, w_sum});
`ifdef RIDER_BATT_LOW_EN
  logic r_batt_low, w_batt_low;
  assign w_batt_low = (r_batt_q < BATT_THRES) ? 1'b1 :
                      ({1'b0, r_batt_q} >= {1'b0, BATT_THRES} + {1'b0, BATT_HYST}) ? 1'b0 : r_batt_low;
  always_ff @(posedge clk)
    r_batt_low <= rst ? 1'b0 : w_batt_low;
  // block on the updating flag so the lockout takes effect with the same sample that sets it
  assign w_blk = w_batt_low;
  assign batt_low = r_batt_low;
`else
  assign w_blk = 1'b0;
  assign batt_low = 1'b0 & (|r_batt_q);
`endif
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = (w_rider_on && !w_blk) ? WAIT : IDLE;
    else if (r_state == WAIT) w_next = w_rider_gone ? IDLE : (w_full && !w_unbal) ? STEER : WAIT;
    else w_next = w_rider_gone ? IDLE : w_tilt ? WAIT : STEER;
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
    en_steer <= !rst && (w_next == STEER);
    rider_off <= rst || (w_next == IDLE);
  end
  assign w_tmr_clr = w_unbal || (r_state != WAIT && w_next == WAIT);
  settle_timer #(.W(TMR_W)) u_tmr (
    .clk(clk),
    .rst(rst),
    .i_clr(w_tmr_clr),
    .i_en(r_state == WAIT),
    .o_full(w_full)
  );
endmodule
